// File: rtl/la_jtag_tap.sv
// la_jtag_tap: device-side JTAG TAP controller running entirely in the core clock domain.
// TCK/TMS/TDI/TRST are oversampled through SYNC flops. TCK edges are detected on the
// synchronized copy, and the 16-state TAP FSM advances only on detected rising edges.
// The TAP has a 4-bit IR and three data registers: IDCODE, BYPASS, and one USER register
// that exchanges data with core logic.
//
// Ports:
//   clk, nreset          core clock, asynchronous active-low reset
//   jtag_tck_in/tms/tdi  JTAG pins from the pad (asynchronous)
//   jtag_trst_in         JTAG TRST pin, active low
//   jtag_tdo_out/oe      TDO and its output enable back to the pad
//   user_capture         value loaded into the USER DR in Capture-DR
//   user_update          USER DR contents latched in Update-DR
//   user_update_valid    one-clk strobe when user_update is written
//   tap_state, tap_reset current TAP state, and a flag that is high in Test-Logic-Reset
module la_jtag_tap #(
    parameter int unsigned    IRW     = 4,
    parameter int unsigned    DRW     = 32,
    parameter logic [31:0]    IDCODE  = 32'h1000_0001,
    parameter logic [IRW-1:0] IR_IDC  = 4'h1,
    parameter logic [IRW-1:0] IR_USER = 4'h8,
    parameter int unsigned    SYNC    = 2
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           jtag_tck_in,
    input  logic           jtag_tms_in,
    input  logic           jtag_tdi_in,
    input  logic           jtag_trst_in,
    output logic           jtag_tdo_out,
    output logic           jtag_tdo_oe,
    input  logic [DRW-1:0] user_capture,
    output logic [DRW-1:0] user_update,
    output logic           user_update_valid,
    output logic [3:0]     tap_state,
    output logic           tap_reset
);

    localparam logic [3:0] TLR   = 4'hF;
    localparam logic [3:0] RTI   = 4'hC;
    localparam logic [3:0] SELDR = 4'h7;
    localparam logic [3:0] CAPDR = 4'h6;
    localparam logic [3:0] SHDR  = 4'h2;
    localparam logic [3:0] EX1DR = 4'h1;
    localparam logic [3:0] PAUDR = 4'h3;
    localparam logic [3:0] EX2DR = 4'h0;
    localparam logic [3:0] UPDDR = 4'h5;
    localparam logic [3:0] SELIR = 4'h4;
    localparam logic [3:0] CAPIR = 4'hE;
    localparam logic [3:0] SHIR  = 4'hA;
    localparam logic [3:0] EX1IR = 4'h9;
    localparam logic [3:0] PAUIR = 4'hB;
    localparam logic [3:0] EX2IR = 4'h8;
    localparam logic [3:0] UPDIR = 4'hD;

    localparam logic [IRW-1:0] IR_CAPTURE = IRW'(2'b01);

    logic [SYNC-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
    logic            tck_s, tms_s, tdi_s, trst_s;
    logic            tck_prev_q, tck_rise, tck_fall;

    logic [3:0]      state_q, state_d;
    logic [IRW-1:0]  ir_q, ir_sr_q;
    logic [31:0]     id_sr_q;
    logic [DRW-1:0]  user_sr_q, user_update_q;
    logic            byp_q, user_valid_q, tdo_q, tdo_oe_q;
    logic            sel_id, sel_user, dr_lsb;

    // All four pins share the same depth, so TMS/TDI stay aligned with TCK.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
        end else begin
            tck_sync  <= {tck_sync[SYNC-2:0], jtag_tck_in};
            tms_sync  <= {tms_sync[SYNC-2:0], jtag_tms_in};
            tdi_sync  <= {tdi_sync[SYNC-2:0], jtag_tdi_in};
            trst_sync <= {trst_sync[SYNC-2:0], jtag_trst_in};
        end
    end

    assign tck_s    = tck_sync[SYNC-1];
    assign tms_s    = tms_sync[SYNC-1];
    assign tdi_s    = tdi_sync[SYNC-1];
    assign trst_s   = trst_sync[SYNC-1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    // DR selection depends only on IR, which changes only in Update-IR or TLR.
    assign sel_id   = (ir_q == IR_IDC);
    assign sel_user = !sel_id && (ir_q == IR_USER);
    assign dr_lsb   = sel_id ? id_sr_q[0] : (sel_user ? user_sr_q[0] : byp_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms_s ? TLR   : RTI;
            RTI:     state_d = tms_s ? SELDR : RTI;
            SELDR:   state_d = tms_s ? SELIR : CAPDR;
            CAPDR:   state_d = tms_s ? EX1DR : SHDR;
            SHDR:    state_d = tms_s ? EX1DR : SHDR;
            EX1DR:   state_d = tms_s ? UPDDR : PAUDR;
            PAUDR:   state_d = tms_s ? EX2DR : PAUDR;
            EX2DR:   state_d = tms_s ? UPDDR : SHDR;
            UPDDR:   state_d = tms_s ? SELDR : RTI;
            SELIR:   state_d = tms_s ? TLR   : CAPIR;
            CAPIR:   state_d = tms_s ? EX1IR : SHIR;
            SHIR:    state_d = tms_s ? EX1IR : SHIR;
            EX1IR:   state_d = tms_s ? UPDIR : PAUIR;
            PAUIR:   state_d = tms_s ? EX2IR : PAUIR;
            EX2IR:   state_d = tms_s ? UPDIR : SHIR;
            UPDIR:   state_d = tms_s ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tck_prev_q    <= 1'b0;
            state_q       <= TLR;
            ir_q          <= IR_IDC;
            ir_sr_q       <= '0;
            id_sr_q       <= '0;
            user_sr_q     <= '0;
            byp_q         <= 1'b0;
            user_update_q <= '0;
            user_valid_q  <= 1'b0;
            tdo_q         <= 1'b0;
            tdo_oe_q      <= 1'b0;
        end else begin
            tck_prev_q   <= tck_s;
            user_valid_q <= 1'b0;
            if (!trst_s) begin
                // TRST wins over any TCK edge; an in-flight shift is simply dropped.
                state_q  <= TLR;
                ir_q     <= IR_IDC;
                tdo_q    <= 1'b0;
                tdo_oe_q <= 1'b0;
            end else begin
                if (tck_rise) begin
                    state_q <= state_d;
                    // Actions are keyed on the state being left, not the one entered.
                    case (state_q)
                        TLR:   ir_q    <= IR_IDC;
                        CAPIR: ir_sr_q <= IR_CAPTURE;
                        SHIR:  ir_sr_q <= {tdi_s, ir_sr_q[IRW-1:1]};
                        UPDIR: ir_q    <= ir_sr_q;
                        CAPDR: begin
                            if (sel_id) id_sr_q <= IDCODE;
                            else if (sel_user) user_sr_q <= user_capture;
                            else byp_q <= 1'b0;
                        end
                        SHDR: begin
                            if (sel_id) id_sr_q <= {tdi_s, id_sr_q[31:1]};
                            else if (sel_user)
                                user_sr_q <= (user_sr_q >> 1) | (DRW'(tdi_s) << (DRW - 1));
                            else byp_q <= tdi_s;
                        end
                        UPDDR: begin
                            if (sel_user) begin
                                user_update_q <= user_sr_q;
                                user_valid_q  <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (tck_fall) begin
                    if (state_q == SHIR) begin
                        tdo_q    <= ir_sr_q[0];
                        tdo_oe_q <= 1'b1;
                    end else if (state_q == SHDR) begin
                        tdo_q    <= dr_lsb;
                        tdo_oe_q <= 1'b1;
                    end else begin
                        tdo_q    <= 1'b0;
                        tdo_oe_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign jtag_tdo_out      = tdo_q;
    assign jtag_tdo_oe       = tdo_oe_q;
    assign user_update       = user_update_q;
    assign user_update_valid = user_valid_q;
    assign tap_state         = state_q;
    assign tap_reset         = (state_q == TLR);

endmodule

// File: tb/tb_la_jtag_tap.sv
// Testbench for la_jtag_tap. It drives TCK at clk/4 and checks the DUT against a
// table-driven 1149.1 reference model after every TCK cycle. On top of that it runs
// directed checks for reset, IDCODE, BYPASS, USER update and TRST.
module tb_la_jtag_tap;

    localparam logic [3:0] ST_TLR  = 4'hF;
    localparam logic [3:0] ST_CAPDR = 4'h6;
    localparam logic [3:0] ST_SHDR = 4'h2;
    localparam logic [3:0] ST_UPDDR = 4'h5;
    localparam logic [3:0] ST_CAPIR = 4'hE;
    localparam logic [3:0] ST_SHIR = 4'hA;
    localparam logic [3:0] ST_UPDIR = 4'hD;

    // Next state indexed by state code, for TMS=0 and TMS=1 (IEEE 1149.1 diagram).
    localparam logic [3:0] NXT0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                         4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    localparam logic [3:0] NXT1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                         4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    logic        clk = 1'b0;
    logic        nreset;
    logic        tck, tms, tdi, trst;
    logic        tdo, tdo_oe;
    logic [31:0] user_capture, user_update;
    logic        user_update_valid;
    logic [3:0]  tap_state;
    logic        tap_reset;

    int n_vec = 0;
    int n_bad = 0;
    int n_pulse = 0;

    // Reference model state
    logic [3:0]  m_state, m_ir, m_ir_sr;
    logic [63:0] m_dr;
    int          m_len;
    logic [31:0] m_upd;
    int          m_pulses;
    logic        m_tdo, m_oe;

    la_jtag_tap dut (
        .clk               (clk),
        .nreset            (nreset),
        .jtag_tck_in       (tck),
        .jtag_tms_in       (tms),
        .jtag_tdi_in       (tdi),
        .jtag_trst_in      (trst),
        .jtag_tdo_out      (tdo),
        .jtag_tdo_oe       (tdo_oe),
        .user_capture      (user_capture),
        .user_update       (user_update),
        .user_update_valid (user_update_valid),
        .tap_state         (tap_state),
        .tap_reset         (tap_reset)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (user_update_valid === 1'b1) n_pulse++;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_TLR; m_ir = 4'h1; m_ir_sr = 4'h0; m_dr = 64'h0; m_len = 1;
        m_upd = 32'h0; m_pulses = 0; m_tdo = 1'b0; m_oe = 1'b0;
    endtask

    task automatic model_trst();
        m_state = ST_TLR; m_ir = 4'h1; m_tdo = 1'b0; m_oe = 1'b0;
    endtask

    task automatic model_fall();
        m_oe  = (m_state == ST_SHIR) || (m_state == ST_SHDR);
        m_tdo = (m_state == ST_SHIR) ? m_ir_sr[0] : ((m_state == ST_SHDR) ? m_dr[0] : 1'b0);
    endtask

    task automatic model_rise(input logic t_ms, input logic t_di);
        if (m_state == ST_TLR) m_ir = 4'h1;
        if (m_state == ST_CAPIR) m_ir_sr = 4'b0001;
        if (m_state == ST_SHIR) m_ir_sr = 4'((m_ir_sr >> 1) | (4'(t_di) << 3));
        if (m_state == ST_UPDIR) m_ir = m_ir_sr;
        if (m_state == ST_CAPDR) begin
            m_len = (m_ir == 4'h1 || m_ir == 4'h8) ? 32 : 1;
            m_dr  = (m_ir == 4'h1) ? 64'h1000_0001 : ((m_ir == 4'h8) ? 64'(user_capture) : 64'h0);
        end
        if (m_state == ST_SHDR) m_dr = (m_dr >> 1) | (64'(t_di) << (m_len - 1));
        if (m_state == ST_UPDDR && m_ir == 4'h8) begin
            m_upd = m_dr[31:0];
            m_pulses++;
        end
        m_state = t_ms ? NXT1[m_state] : NXT0[m_state];
    endtask

    // One TCK period = 4 clks; called just after a posedge. The checks see the fall
    // of this cycle and the rise of the previous one.
    task automatic tck_cycle(input logic t_ms, input logic t_di);
        tck = 1'b0; tms = t_ms; tdi = t_di;
        model_fall();
        repeat (2) @(posedge clk);
        #1 tck = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("tap_state", 64'(tap_state), 64'(m_state));
        check("tap_reset", 64'(tap_reset), 64'(m_state == ST_TLR));
        check("tdo", 64'(tdo), 64'(m_tdo));
        check("tdo_oe", 64'(tdo_oe), 64'(m_oe));
        check("user_update", 64'(user_update), 64'(m_upd));
        check("valid_pulses", 64'(n_pulse), 64'(m_pulses));
        model_rise(t_ms, t_di);
    endtask

    task automatic load_ir(input logic [3:0] op, output logic [1:0] cap);
        tck_cycle(1'b0, 1'b0); tck_cycle(1'b1, 1'b0); tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tck_cycle(i == 3, op[i]);
            if (i < 2) cap[i] = tdo;
        end
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0);
    endtask

    task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                            output logic oe_ok);
        dout = 64'h0; oe_ok = 1'b1;
        tck_cycle(1'b0, 1'b0); tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i]);
            dout[i] = tdo;
            oe_ok &= tdo_oe;
        end
        tck_cycle(1'b1, 1'b0);
        oe_ok &= !tdo_oe;
        tck_cycle(1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] dout;
        logic        oe_ok;
        logic [1:0]  cap;
        int          pulses_before;

        nreset = 1'b0; tck = 1'b0; tms = 1'b0; tdi = 1'b0; trst = 1'b1;
        user_capture = 32'hDEAD_BEEF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 64'(tap_state), 64'hF);
        check("rst_tap_reset", 64'(tap_reset), 64'h1);
        check("rst_tdo", 64'(tdo), 64'h0);
        check("rst_tdo_oe", 64'(tdo_oe), 64'h0);
        check("rst_user_update", 64'(user_update), 64'h0);
        check("rst_valid", 64'(user_update_valid), 64'h0);
        nreset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Random walk, then five TMS=1 rises reach TLR from wherever it landed
        for (int i = 0; i < 24; i++) tck_cycle(1'($urandom), 1'($urandom));
        for (int i = 0; i < 6; i++) tck_cycle(1'b1, 1'($urandom));
        check("tlr_state", 64'(tap_state), 64'hF);
        check("tlr_tap_reset", 64'(tap_reset), 64'h1);

        // IDCODE selected after TLR
        shift_dr(32, 64'($urandom), dout, oe_ok);
        check("idcode_stream", dout, 64'h1000_0001);
        check("idcode_oe", 64'(oe_ok), 64'h1);

        // BYPASS: one-bit delay with leading 0
        load_ir(4'hF, cap);
        shift_dr(8, 64'hA5, dout, oe_ok);
        check("bypass_stream", dout, 64'h4A);

        // USER register capture and update
        load_ir(4'h8, cap);
        check("ir_capture_bits", 64'(cap), 64'h1);
        pulses_before = n_pulse;
        shift_dr(32, 64'h1234_5678, dout, oe_ok);
        check("user_capture_stream", dout, 64'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        #1;
        check("user_update_value", 64'(user_update), 64'h1234_5678);
        check("user_valid_once", 64'(n_pulse - pulses_before), 64'h1);

        // TRST mid-shift with USER selected
        pulses_before = n_pulse;
        tck_cycle(1'b0, 1'b0); tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tck_cycle(1'b0, 1'($urandom));
        trst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("trst_state", 64'(tap_state), 64'hF);
        check("trst_tap_reset", 64'(tap_reset), 64'h1);
        model_trst();
        repeat (3) @(posedge clk);
        #1 trst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("trst_no_pulse", 64'(n_pulse - pulses_before), 64'h0);
        check("trst_user_update", 64'(user_update), 64'h1234_5678);
        check("trst_tdo_oe", 64'(tdo_oe), 64'h0);
        shift_dr(32, 64'($urandom), dout, oe_ok);
        check("trst_ir_idcode", dout, 64'h1000_0001);

        // Random TMS/TDI against the reference model
        user_capture = $urandom;
        for (int i = 0; i < 300; i++) tck_cycle(1'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
